// File: rtl/core_rc_ctrl.sv
// Row sequencer for core_rc: scale handshake, credit-metered input, output drain, scale clear.
// Optional per-state watchdog on WAIT_SCALE/DRAIN enabled by defining RC_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for row_start
// WAIT_SCALE | recompute row: waiting for RMS scale; input prefill allowed
// STREAM     | feeding elements to core_rc under FIFO credit
// DRAIN      | all elements issued, waiting for core_rc returns
// DONE       | one-cycle close-out; row_done/rc_scale_clear follow
module core_rc_ctrl #(
  parameter int ROW_LEN_WIDTH         = 12,
  parameter int RECOMPUTE_SCALE_WIDTH = 24,
  parameter int RECOMPUTE_SHIFT_WIDTH = 5,
  parameter int RECOMPUTE_FIFO_DEPTH  = 16
`ifdef RC_TIMEOUT_EN
  , parameter int TIMEOUT_WIDTH       = 10
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             row_start,
  input  logic                             row_recompute,
  input  logic [ROW_LEN_WIDTH-1:0]         cfg_row_len,
  input  logic [RECOMPUTE_SHIFT_WIDTH-1:0] cfg_rc_shift,
  input  logic [RECOMPUTE_SCALE_WIDTH-1:0] scale_in,
  input  logic                             scale_in_vld,
  input  logic                             src_vld,
  output logic                             src_rdy,
  output logic                             rc_in_data_vld,
  input  logic                             rc_out_vld,
  input  logic                             rc_fifo_full,
  output logic                             recompute_needed,
  output logic [RECOMPUTE_SCALE_WIDTH-1:0] rc_scale,
  output logic                             rc_scale_vld,
  output logic                             rc_scale_clear,
  output logic [RECOMPUTE_SHIFT_WIDTH-1:0] rms_rc_shift,
  output logic                             row_busy,
  output logic                             row_done,
  output logic                             error
);

  typedef enum logic [2:0] {IDLE, WAIT_SCALE, STREAM, DRAIN, DONE} state_t;

  localparam logic [ROW_LEN_WIDTH:0] FIFO_DEPTH = RECOMPUTE_FIFO_DEPTH[ROW_LEN_WIDTH:0];

  state_t                   state_q, state_d;
  logic [ROW_LEN_WIDTH-1:0] len_q, issued_q, returned_q;
  logic                     rec_q;
  logic [ROW_LEN_WIDTH:0]   outstanding, issued_inc, returned_inc;
  logic                     ret_counted, ret_over, err_d, wd_fire;

  assign row_busy         = (state_q != IDLE);
  assign recompute_needed = row_busy & rec_q;
  assign outstanding      = {1'b0, issued_q} - {1'b0, returned_q};
  assign src_rdy          = ((state_q == WAIT_SCALE) || (state_q == STREAM)) &&
                            (issued_q < len_q) && (outstanding < FIFO_DEPTH);
  assign rc_in_data_vld   = src_vld & src_rdy;

  // Returns are only counted inside a row; a return in IDLE is flagged separately.
  assign ret_counted  = rc_out_vld & row_busy;
  assign issued_inc   = {1'b0, issued_q} + {{ROW_LEN_WIDTH{1'b0}}, rc_in_data_vld};
  assign returned_inc = {1'b0, returned_q} + {{ROW_LEN_WIDTH{1'b0}}, ret_counted};
  assign ret_over     = (returned_inc > issued_inc);

  assign err_d = (row_start && (state_q != IDLE)) ||
                 (scale_in_vld && (state_q != WAIT_SCALE)) ||
                 (rc_out_vld && (state_q == IDLE)) ||
                 rc_fifo_full || ret_over || wd_fire;

`ifdef RC_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_WIDTH-1:0] wd_q;
  logic                     wd_active, wd_event;

  assign wd_active = (state_q == WAIT_SCALE) || (state_q == DRAIN);
  assign wd_event  = scale_in_vld | rc_out_vld;
  // Fires on the idle cycle that brings the count to 2^TIMEOUT_WIDTH-1.
  assign wd_fire   = wd_active && !wd_event && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || !wd_active || wd_event) wd_q <= '0;
    else                               wd_q <= wd_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (row_start) begin
          if (cfg_row_len == '0) state_d = DONE;
          else if (row_recompute) state_d = WAIT_SCALE;
          else                    state_d = STREAM;
        end
      end
      WAIT_SCALE: begin
        if (scale_in_vld) state_d = STREAM;
        else if (wd_fire) state_d = DONE;
      end
      STREAM:  if (issued_q == len_q) state_d = DRAIN;
      DRAIN: begin
        if (returned_q == len_q) state_d = DONE;
        else if (wd_fire)        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      issued_q       <= '0;
      returned_q     <= '0;
      rec_q          <= 1'b0;
      rc_scale       <= '0;
      rc_scale_vld   <= 1'b0;
      rc_scale_clear <= 1'b0;
      rms_rc_shift   <= '0;
      row_done       <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rc_scale_vld   <= 1'b0;
      rc_scale_clear <= 1'b0;
      row_done       <= 1'b0;
      if (state_q == IDLE) begin
        issued_q   <= '0;
        returned_q <= '0;
        if (row_start) begin
          len_q        <= cfg_row_len;
          rec_q        <= row_recompute;
          rms_rc_shift <= cfg_rc_shift;
        end
      end else begin
        issued_q   <= issued_inc[ROW_LEN_WIDTH-1:0];
        returned_q <= returned_inc[ROW_LEN_WIDTH-1:0];
      end
      if ((state_q == WAIT_SCALE) && scale_in_vld) begin
        rc_scale     <= scale_in;
        rc_scale_vld <= 1'b1;
      end
      if (state_q == DONE) begin
        row_done       <= 1'b1;
        rc_scale_clear <= rec_q;
        if (rec_q) rc_scale <= '0;
      end
      if (err_d) error <= 1'b1;
    end
  end

endmodule
